regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, number of architectural registers (power of 2, >=4); AW = log2(NREG).
REQ-003 SHALL have parameter NRP, default 2, number of read ports.
REQ-004 SHALL have port i_clk  input  1  single clock, all state updates on its rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port i_rs_addr  input  NRP*AW  read addresses, port k in bits [k*AW +: AW].
REQ-007 SHALL have port o_rs_data  output  NRP*XLEN  read data, port k in bits [k*XLEN +: XLEN].
REQ-008 SHALL have port o_rs_busy  output  NRP  per read port, the operand has an outstanding producer.
REQ-009 SHALL have port i_wr_en, i_wr_addr (AW), i_wr_data (XLEN)  input  writeback port.
REQ-010 SHALL have port i_iss_en, i_iss_rd (AW)  input  issue port, marks the destination register pending.
REQ-011 SHALL have port i_clr  input  1  request a sequential clear of all registers.
REQ-012 SHALL have port o_ready  output  1  high when in IDLE state.

Function
REQ-013 Register 0 SHALL always read 0, never report busy, and ignore writes and issues.
REQ-014 Reads SHALL be combinational, zero latency, on every port independently.
REQ-015 If i_wr_en and i_wr_addr equals a nonzero read address, that port SHALL return i_wr_data in the same cycle (bypass).
REQ-016 Write SHALL update the register array at the rising edge when i_wr_en=1, addr!=0, state=IDLE.
REQ-017 Busy bit SHALL be set at the edge where i_iss_en=1, i_iss_rd!=0, state=IDLE.
REQ-018 Busy bit SHALL be cleared at the edge where a write to that address occurs, unless an issue to the same address occurs in the same cycle (issue wins: bit stays set).
REQ-019 o_rs_busy[k] SHALL equal busy[addr_k] AND NOT (i_wr_en with matching nonzero address), so the bypassed operand is not reported busy.
REQ-020 FSM states SHALL be IDLE and CLEAR; IDLE->CLEAR when i_clr=1; CLEAR->IDLE after the counter reaches NREG-1.
REQ-021 In CLEAR, a counter SHALL start at 1 and on each edge zero register[counter] and its busy bit, then increment; CLEAR lasts exactly NREG-1 cycles.
REQ-022 In CLEAR, writes, issues and further i_clr SHALL be ignored; o_ready=0; o_rs_busy SHALL be 1 for every nonzero read address.
REQ-023 In CLEAR, read data SHALL be the currently stored value (no bypass).
REQ-024 i_clr together with i_wr_en/i_iss_en in the IDLE cycle SHALL perform that write/issue, then enter CLEAR (it is subsequently cleared).

Reset
REQ-025 On i_rst=1, asynchronously: all registers 0, all busy bits 0, state IDLE, counter 1.
REQ-026 Reset asserted mid-CLEAR SHALL abort the clear and yield the REQ-025 state; o_ready=1 while reset is held.
REQ-027 After reset release, the first edge SHALL accept writes and issues.

Structure
REQ-028 A shared package regfile_pkg SHALL hold the state enum (IDLE, CLEAR) and default parameter constants.
REQ-029 The clear FSM and counter SHALL be one sub-module, regfile_clr_fsm, outputting state, clear index and clear strobe.
REQ-030 The register array and the busy vector SHALL remain in regfile_sb.

Verification
REQ-031 Write x5=0xDEADBEEF, next cycle read port 0 addr 5 -> 0xDEADBEEF, busy 0.
REQ-032 Same cycle: wr x7=0x12345678 and read addr 7 on both ports -> both 0x12345678, o_rs_busy=0; write to x0=0xFFFFFFFF -> x0 reads 0.
REQ-033 Issue rd=9 -> next cycle busy on addr 9 = 1; writeback x9=0x55 with issue rd=9 same cycle -> busy stays 1, data 0x55.
REQ-034 Fill x1..x31 with nonzero values, pulse i_clr -> o_ready low exactly 31 cycles, all reads 0 afterwards, writes during CLEAR dropped.
REQ-035 Assert i_rst at clear cycle 10 -> all regs 0, o_ready=1 immediately, write x3=0x1 after release succeeds.
REQ-036 Parameter sweep XLEN=64, NREG=16, NRP=3: REQ-031..034 pass with CLEAR lasting 15 cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding and default sizing for the scoreboarded register file.
package regfile_pkg;
   typedef enum logic {IDLE, CLEAR} state_e;
   localparam int XLEN_DEF = 32;
   localparam int NREG_DEF = 32;
   localparam int NRP_DEF  = 2;
endpackage

// File: rtl/regfile_clr_fsm.sv
// regfile_clr_fsm: sequential clear sequencer, walks registers 1..NREG-1 one per cycle.
module regfile_clr_fsm
   import regfile_pkg::*;
#(
   parameter int NREG = NREG_DEF,
   parameter int AW   = $clog2(NREG)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_clr,
   output state_e        o_state,
   output logic [AW-1:0] o_idx,
   output logic          o_clr_stb
);
   state_e        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          last;
   assign last = idx_q == AW'(NREG - 1);
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         idx_q   <= AW'(1);
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      if (state_q == IDLE) begin
         state_d = i_clr ? CLEAR : IDLE;
      end else begin
         state_d = last ? IDLE : CLEAR;
         idx_d   = last ? AW'(1) : idx_q + AW'(1);
      end
   end
   assign o_state   = state_q;
   assign o_idx     = idx_q;
   assign o_clr_stb = state_q == CLEAR;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with per-register busy scoreboard,
// write-to-read bypass and a sequential clear mode.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int NREG = NREG_DEF,
   parameter int NRP  = NRP_DEF,
   parameter int AW   = $clog2(NREG)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [NRP*AW-1:0] i_rs_addr,
   output logic [NRP*XLEN-1:0] o_rs_data,
   output logic [NRP-1:0]    o_rs_busy,
   input  logic              i_wr_en,
   input  logic [AW-1:0]     i_wr_addr,
   input  logic [XLEN-1:0]   i_wr_data,
   input  logic              i_iss_en,
   input  logic [AW-1:0]     i_iss_rd,
   input  logic              i_clr,
   output logic              o_ready
);
   logic [XLEN-1:0] rf_q [NREG];
   logic [XLEN-1:0] rf_d [NREG];
   logic [NREG-1:0] busy_q, busy_d;
   state_e          state;
   logic [AW-1:0]   clr_idx;
   logic            clr_stb, idle, wr_ok, iss_ok;

   regfile_clr_fsm #(.NREG(NREG), .AW(AW)) u_clr_fsm (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_clr    (i_clr),
      .o_state  (state),
      .o_idx    (clr_idx),
      .o_clr_stb(clr_stb)
   );

   assign idle    = state == IDLE;
   assign o_ready = idle;
   assign wr_ok   = idle && i_wr_en && i_wr_addr != '0;
   assign iss_ok  = idle && i_iss_en && i_iss_rd != '0;

   // Issue is applied after writeback so a same-cycle issue keeps the bit set.
   always_comb begin
      rf_d   = rf_q;
      busy_d = busy_q;
      if (clr_stb) begin
         rf_d[clr_idx]   = '0;
         busy_d[clr_idx] = 1'b0;
      end
      if (wr_ok) begin
         rf_d[i_wr_addr]   = i_wr_data;
         busy_d[i_wr_addr] = 1'b0;
      end
      if (iss_ok) busy_d[i_iss_rd] = 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int r = 0; r < NREG; r++) rf_q[r] <= '0;
         busy_q <= '0;
      end else begin
         rf_q   <= rf_d;
         busy_q <= busy_d;
      end
   end

   for (genvar k = 0; k < NRP; k++) begin : g_rd
      logic [AW-1:0] ra;
      logic          byp;
      assign ra  = i_rs_addr[k*AW +: AW];
      assign byp = wr_ok && i_wr_addr == ra;
      assign o_rs_data[k*XLEN +: XLEN] = ra == '0 ? '0 : byp ? i_wr_data : rf_q[ra];
      assign o_rs_busy[k] = ra != '0 && (!idle || (busy_q[ra] && !byp));
   end
endmodule
